// File: rtl/fxp_radix_multiplier_pkg.sv
// Shared types and constants for the radix-2^K fixed-point multiplier.
package fxp_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  function automatic int unsigned iter_count(input int unsigned n, input int unsigned k);
    return n / k;
  endfunction

endpackage

// File: rtl/fxp_radix_multiplier_round_sat.sv
// Rescales a 2N-bit exact product by D fractional bits, optionally rounds half up,
// and clamps or wraps to N bits, flagging any out-of-range result.
module fxp_mult_round_sat
  import fxp_mult_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned D   = 16,
  parameter int unsigned SAT = 1
) (
  input  logic [2*N-1:0] p,
  input  logic           is_signed,
  input  logic           round_mode,
  output logic [N-1:0]   c,
  output logic           ovf
);

  // One guard bit keeps the rounding increment from wrapping the product.
  localparam int unsigned   W     = 2 * N + 1;
  localparam logic [W-1:0]  HALF  = (D > 0) ? (W'(1) << ((D > 0) ? (D - 1) : 0)) : '0;
  localparam logic [N-1:0]  S_MAX = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0]  S_MIN = {1'b1, {(N - 1){1'b0}}};

  logic [W-1:0] ext;
  logic [W-1:0] rnd;
  logic [W-1:0] q;

  always_comb begin
    ext = {is_signed & p[2*N-1], p};
    rnd = ext + ((round_mode == RND_HALF_UP) ? HALF : '0);
    if (is_signed) begin
      q = $signed(rnd) >>> D;
    end else begin
      q = rnd >> D;
    end

    if (is_signed) begin
      ovf = !((&q[W-1:N-1]) || (~|q[W-1:N-1]));
    end else begin
      ovf = |q[W-1:N];
    end

    c = q[N-1:0];
    if (ovf && (SAT != 0)) begin
      if (is_signed) begin
        c = q[W-1] ? S_MIN : S_MAX;
      end else begin
        c = '1;
      end
    end
  end

endmodule

// File: rtl/fxp_radix_multiplier.sv
// Iterative fixed-point multiplier retiring K multiplier bits per cycle, with
// val/rdy handshakes, per-transaction signedness/rounding and saturation.
module fxp_radix_multiplier
  import fxp_mult_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned D   = 16,
  parameter int unsigned K   = 2,
  parameter int unsigned SAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  input  logic         round_mode,
  input  logic         send_rdy,
  output logic         send_val,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int unsigned    ITER = iter_count(N, K);
  localparam int unsigned    CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

  state_e         state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] a_sh;
  logic [N-1:0]   b_sh;
  logic           sgn;
  logic           rnd;

  logic [K-1:0]   digit;
  logic           last;
  logic [2*N-1:0] pp;
  logic [2*N-1:0] acc_nxt;
  logic [N-1:0]   rs_c;
  logic           rs_ovf;

  assign digit = b_sh[K-1:0];
  assign last  = (cnt == LAST);

  // a_sh is sign-extended at capture, so the product is exact modulo 2^(2N);
  // in signed mode only the top bit of the final digit carries negative weight.
  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if (digit[j]) begin
        if ((j == K - 1) && last && sgn) begin
          pp = pp - (a_sh << j);
        end else begin
          pp = pp + (a_sh << j);
        end
      end
    end
    acc_nxt = acc + pp;
  end

  fxp_mult_round_sat #(
    .N   (N),
    .D   (D),
    .SAT (SAT)
  ) u_round_sat (
    .p          (acc_nxt),
    .is_signed  (sgn),
    .round_mode (rnd),
    .c          (rs_c),
    .ovf        (rs_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      sgn      <= 1'b0;
      rnd      <= 1'b0;
      c        <= '0;
      ovf      <= 1'b0;
      send_val <= 1'b0;
      recv_rdy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (recv_val) begin
            state    <= CALC;
            cnt      <= '0;
            acc      <= '0;
            a_sh     <= is_signed ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
            b_sh     <= b;
            sgn      <= is_signed;
            rnd      <= round_mode;
            recv_rdy <= 1'b0;
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << K;
          b_sh <= b_sh >> K;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state    <= DONE;
            c        <= rs_c;
            ovf      <= rs_ovf;
            send_val <= 1'b1;
          end
        end
        DONE: begin
          if (send_rdy) begin
            state    <= IDLE;
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          send_val <= 1'b0;
          recv_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_radix_multiplier.sv
// Randomized self-checking bench for fxp_radix_multiplier and fxp_mult_round_sat.
module tb_fxp_radix_multiplier;

  localparam int unsigned N   = 32;
  localparam int unsigned D   = 16;
  localparam int unsigned K   = 2;
  localparam int unsigned LAT = N / K;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val;
  logic        recv_rdy;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        round_mode;
  logic        send_rdy = 1'b0;
  logic        send_val;
  logic [31:0] c;
  logic        ovf;

  logic [63:0] rs_p;
  logic        rs_sgn;
  logic        rs_rnd;
  logic [31:0] rs_c;
  logic        rs_ovf;

  always #5 clk = ~clk;

  fxp_radix_multiplier #(
    .N   (N),
    .D   (D),
    .K   (K),
    .SAT (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .recv_val   (recv_val),
    .recv_rdy   (recv_rdy),
    .a          (a),
    .b          (b),
    .is_signed  (is_signed),
    .round_mode (round_mode),
    .send_rdy   (send_rdy),
    .send_val   (send_val),
    .c          (c),
    .ovf        (ovf)
  );

  fxp_mult_round_sat #(
    .N   (N),
    .D   (D),
    .SAT (0)
  ) rs_wrap (
    .p          (rs_p),
    .is_signed  (rs_sgn),
    .round_mode (rs_rnd),
    .c          (rs_c),
    .ovf        (rs_ovf)
  );

  typedef struct {
    logic [31:0] c;
    logic        ovf;
    int unsigned acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        rnd;
    logic        sat;
    logic [31:0] c;
    logic        o;
  } vec_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int          rdy_mode = 0;
  logic        prev_sv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = 64'(x);
    uy = 64'(y);
    return ux * uy;
  endfunction

  function automatic void round_sat_model(input logic [63:0] p, input logic sgn, input logic rnd,
                                          input logic sat, output logic [31:0] cm, output logic om);
    logic signed [66:0] x;
    logic signed [66:0] q;
    x = sgn ? {{3{p[63]}}, p} : {3'b000, p};
    if (rnd) x = x + 67'sd32768;
    q = x >>> 16;
    if (sgn) om = (q > 67'sd2147483647) || (q < -67'sd2147483648);
    else     om = (q > 67'sd4294967295);
    cm = q[31:0];
    if (om && sat) begin
      if (sgn) cm = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else     cm = 32'hFFFF_FFFF;
    end
  endfunction

  // Compare process: checks every response cycle against the queued model result.
  always @(negedge clk) begin
    if (reset) begin
      prev_sv = 1'b0;
    end else begin
      if (send_val) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_send_val: got send_val=1 expected no response (t=%0t)", $time);
        end else begin
          check("c", c, exp_q[0].c);
          check("ovf", ovf, exp_q[0].ovf);
          check("recv_rdy_in_done", recv_rdy, 0);
          if (!prev_sv) check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(LAT));
        end
      end
      prev_sv = send_val;
      case (rdy_mode)
        1:       send_rdy = 1'b0;
        2:       send_rdy = 1'b1;
        default: send_rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (send_val && send_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic send_op(input logic [31:0] xa, input logic [31:0] xb, input logic sgn,
                         input logic rnd, input bit junk);
    logic [31:0] cm;
    logic        om;
    bit          ok;
    ok = 0;
    @(negedge clk);
    a = xa; b = xb; is_signed = sgn; round_mode = rnd; recv_val = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (recv_rdy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      fail_now("accept_timeout");
      recv_val = 1'b0;
      return;
    end
    round_sat_model(prod(xa, xb, sgn), sgn, rnd, 1'b1, cm, om);
    exp_q.push_back('{c: cm, ovf: om, acc_cyc: cyc + 1});
    @(negedge clk);
    recv_val = 1'b0;
    if (junk) begin
      for (int i = 0; i < 8; i++) begin
        recv_val   = 1'($urandom_range(0, 1));
        a          = $urandom;
        b          = $urandom;
        is_signed  = 1'($urandom_range(0, 1));
        round_mode = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      recv_val = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    fail_now("response_timeout");
    exp_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] cm, cap_c, xa, xb;
    logic        om, cap_o, sg, rn;
    bit          hit;

    vecs = '{
      '{32'h0001_8000, 32'h0002_0000, 1'b1, 1'b0, 1'b1, 32'h0003_0000, 1'b0},
      '{32'hFFFE_8000, 32'h0002_0000, 1'b1, 1'b0, 1'b1, 32'hFFFD_0000, 1'b0},
      '{32'h0000_0001, 32'h0000_8000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0},
      '{32'h0000_0001, 32'h0000_8000, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b0},
      '{32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0},
      '{32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0},
      '{32'h7FFF_0000, 32'h0002_0000, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1},
      '{32'h7FFF_0000, 32'h0002_0000, 1'b0, 1'b0, 1'b1, 32'hFFFE_0000, 1'b0},
      '{32'h7FFF_0000, 32'h0002_0000, 1'b1, 1'b0, 1'b0, 32'hFFFE_0000, 1'b1}
    };

    reset = 1'b1; recv_val = 1'b0; a = '0; b = '0; is_signed = 1'b0; round_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_recv_rdy", recv_rdy, 1);
    check("rst_send_val", send_val, 0);
    check("rst_c", c, 0);
    check("rst_ovf", ovf, 0);

    // Hand-computed results pin the reference model.
    foreach (vecs[i]) begin
      round_sat_model(prod(vecs[i].a, vecs[i].b, vecs[i].sgn), vecs[i].sgn, vecs[i].rnd,
                      vecs[i].sat, cm, om);
      check($sformatf("model_c[%0d]", i), cm, vecs[i].c);
      check($sformatf("model_ovf[%0d]", i), om, vecs[i].o);
    end

    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].sat) send_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rnd, 1);
    end
    wait_done();

    for (int n = 0; n < 120; n++) begin
      sg = 1'($urandom_range(0, 1));
      rn = 1'($urandom_range(0, 1));
      xa = $urandom >> $urandom_range(0, 31);
      xb = $urandom >> $urandom_range(0, 31);
      if (sg && $urandom_range(0, 1) != 0) xa = -xa;
      if (sg && $urandom_range(0, 1) != 0) xb = -xb;
      send_op(xa, xb, sg, rn, 1);
    end
    wait_done();

    // Backpressure: DONE holds with stable outputs until send_rdy.
    rdy_mode = 1;
    send_op(32'h0001_8000, 32'h0002_0000, 1'b1, 1'b0, 0);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (send_val) begin
        hit = 1;
        break;
      end
    end
    if (!hit) fail_now("bp_send_val_timeout");
    cap_c = c;
    cap_o = ovf;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_send_val", send_val, 1);
      check("bp_c_stable", c, cap_c);
      check("bp_ovf_stable", ovf, cap_o);
      check("bp_recv_rdy", recv_rdy, 0);
    end
    rdy_mode = 2;
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (send_val && send_rdy) begin
        hit = 1;
        break;
      end
    end
    if (!hit) fail_now("bp_handshake_timeout");
    #1;
    check("bp_after_send_val", send_val, 0);
    check("bp_after_recv_rdy", recv_rdy, 1);
    rdy_mode = 0;
    wait_done();

    // Reset in the middle of CALC abandons the operation immediately.
    send_op(32'h0001_8000, 32'h0002_0000, 1'b1, 1'b0, 0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_send_val", send_val, 0);
    check("midrst_recv_rdy", recv_rdy, 1);
    check("midrst_c", c, 0);
    check("midrst_ovf", ovf, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send_op(32'h0001_8000, 32'h0002_0000, 1'b1, 1'b0, 1);
    wait_done();

    // Wrapping rounder/saturator (SAT=0) on its own.
    rs_p = 64'h0000_FFFE_0000_0000; rs_sgn = 1'b1; rs_rnd = 1'b0;
    #1;
    check("rs_wrap_c", rs_c, 32'hFFFE_0000);
    check("rs_wrap_ovf", rs_ovf, 1);
    rs_p = 64'hFFFF_FFFF_FFFF_8000; rs_sgn = 1'b0; rs_rnd = 1'b1;
    #1;
    check("rs_rndovf_c", rs_c, 32'h0000_0000);
    check("rs_rndovf_ovf", rs_ovf, 1);
    for (int n = 0; n < 40; n++) begin
      rs_p   = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 40);
      rs_sgn = 1'($urandom_range(0, 1));
      rs_rnd = 1'($urandom_range(0, 1));
      if (rs_sgn && $urandom_range(0, 1) != 0) rs_p = -rs_p;
      #1;
      round_sat_model(rs_p, rs_sgn, rs_rnd, 1'b0, cm, om);
      check("rs_rand_c", rs_c, cm);
      check("rs_rand_ovf", rs_ovf, om);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
